// File: rtl/pipelined_decomposed_rca.sv
// Pipelined ripple-carry adder/subtractor: one SEGW-bit segment resolved per clock,
// with operand skew and result deskew so a full result emerges every enabled cycle.
module pipelined_decomposed_rca #(
  parameter int NBIT = 16,
  parameter int NSEG = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ce,
  input  logic            i_in_valid,
  input  logic [NBIT-1:0] i_a,
  input  logic [NBIT-1:0] i_b,
  input  logic            i_cin,
  input  logic            i_sub,
  output logic            o_out_valid,
  output logic [NBIT-1:0] o_s,
  output logic            o_cout,
  output logic            o_ovf
);

  localparam int SEGW = NBIT / NSEG;

  // Index p of these arrays is the pipeline position after p segments are resolved.
  logic [NBIT-1:0] w_a [0:NSEG-1];
  logic [NBIT-1:0] w_b [0:NSEG-1];
  logic [NBIT-1:0] w_s [0:NSEG];
  logic            w_c [0:NSEG];
  logic            w_v [0:NSEG];
  logic            w_ovf;

  logic [NBIT-1:0] r_in_a;
  logic [NBIT-1:0] r_in_b;
  logic            r_in_c;
  logic            r_in_v;

  // Acceptance register: subtract inversion and forced carry are folded in here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_a <= '0;
      r_in_b <= '0;
      r_in_c <= 1'b0;
      r_in_v <= 1'b0;
    end else if (i_ce) begin
      r_in_v <= i_in_valid;
      if (i_in_valid) begin
        r_in_a <= i_a;
        r_in_b <= i_sub ? ~i_b : i_b;
        r_in_c <= i_sub | i_cin;
      end
    end
  end

  assign w_a[0] = r_in_a;
  assign w_b[0] = r_in_b;
  assign w_c[0] = r_in_c;
  assign w_v[0] = r_in_v;
  assign w_s[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi <= NSEG; gi++) begin : g_stage
      localparam int LO = (gi - 1) * SEGW;

      logic [SEGW-1:0] w_a_seg;
      logic [SEGW-1:0] w_b_seg;
      logic [SEGW:0]   w_full;
      logic [NBIT-1:0] r_s;
      logic            r_c;
      logic            r_v;

      assign w_a_seg = w_a[gi-1][LO +: SEGW];
      assign w_b_seg = w_b[gi-1][LO +: SEGW];
      assign w_full  = {1'b0, w_a_seg} + {1'b0, w_b_seg} + {{SEGW{1'b0}}, w_c[gi-1]};

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_s <= '0;
          r_c <= 1'b0;
          r_v <= 1'b0;
        end else if (i_ce) begin
          r_v <= w_v[gi-1];
          if (w_v[gi-1]) begin
            r_s              <= w_s[gi-1];
            r_s[LO +: SEGW]  <= w_full[SEGW-1:0];
            r_c              <= w_full[SEGW];
          end
        end
      end

      assign w_s[gi] = r_s;
      assign w_c[gi] = r_c;
      assign w_v[gi] = r_v;

      if (gi < NSEG) begin : g_skew
        logic [NBIT-1:0] r_a;
        logic [NBIT-1:0] r_b;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) begin
            r_a <= '0;
            r_b <= '0;
          end else if (i_ce && w_v[gi-1]) begin
            r_a <= w_a[gi-1];
            r_b <= w_b[gi-1];
          end
        end

        assign w_a[gi] = r_a;
        assign w_b[gi] = r_b;
      end else begin : g_last
        logic w_c_into_msb;
        logic r_ovf;

        // Carry into the MSB recovered from the MSB sum bit and its operands.
        assign w_c_into_msb = w_a_seg[SEGW-1] ^ w_b_seg[SEGW-1] ^ w_full[SEGW-1];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) begin
            r_ovf <= 1'b0;
          end else if (i_ce && w_v[gi-1]) begin
            r_ovf <= w_c_into_msb ^ w_full[SEGW];
          end
        end

        assign w_ovf = r_ovf;
      end
    end
  endgenerate

  assign o_out_valid = w_v[NSEG];
  assign o_s         = w_s[NSEG];
  assign o_cout      = w_c[NSEG];
  assign o_ovf       = w_ovf;

endmodule

// File: doc/pipelined_decomposed_rca.md
# pipelined_decomposed_rca

Parametrised, pipelined ripple-carry adder/subtractor. The NBIT datapath is split into NSEG equal segments, and one segment is resolved per clock, with the inter-segment carry held in a register. Results leave at one per cycle after a fixed NSEG-cycle latency. It is the clocked successor of the combinational decomposed RCA, for datapaths where a full-width ripple does not close timing. It adds carry-in, subtract mode, carry-out, signed overflow and a valid/enable handshake.

## Interface
- NBIT, 16: operand and sum width; must be divisible by NSEG.
- NSEG, 4: number of segments and pipeline stages, ≥1; segment width SEGW = NBIT/NSEG.
- CLK  in  1  clock, rising-edge active.
- RST_N  in  1  reset; asynchronous, active-low.
- CE  in  1  global clock enable; 0 freezes every register in the block.
- IN_VALID  in  1  A/B/CIN/SUB are valid this cycle.
- A  in  NBIT  operand A.
- B  in  NBIT  operand B.
- CIN  in  1  carry-in; used only when SUB=0.
- SUB  in  1  0: S = A+B+CIN; 1: S = A−B, computed as A+~B+1 with CIN ignored.
- OUT_VALID  out  1  S/COUT/OVF hold a new result this cycle.
- S  out  NBIT  sum/difference, modulo 2^NBIT.
- COUT  out  1  carry out of bit NBIT−1; in subtract mode 1 = no borrow (A ≥ B unsigned).
- OVF  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

## Operation
- Input acceptance: an operation is accepted on a rising edge with CE=1 and IN_VALID=1. There is no back-pressure; every accepted operation completes.
- Stage k (k = 0..NSEG−1) adds segment k of A and of the effective B, plus the carry from stage k−1.
  - Stage 0 uses CIN, or 1 when SUB=1.
  - Stage k registers its SEGW-bit partial sum and its carry-out.
- Operand skew: segments k+1..NSEG−1 of A and effective B travel through delay registers alongside the operation.
- Result deskew: completed low segments travel through delay registers so that all of S emerges on the same cycle.
- Per-stage valid: each stage carries a valid bit. Its data registers load only when CE=1 and the incoming valid is 1; otherwise they hold. Bubbles therefore never disturb S/COUT/OVF, which keep the last valid result.
- Output registers:
  - OVF is computed in the last stage from the carry into and out of bit NBIT−1, and is registered with S and COUT.
  - OUT_VALID is the last-stage valid bit. It is high for exactly one cycle per accepted operation, or held while CE=0.
- Width rules: no saturation. S wraps modulo 2^NBIT, and COUT/OVF report the condition.
- NSEG=1: a single registered full-width add with latency 1.

## Timing
- Reset (RST_N=0): all valid bits, data registers, S, COUT, OVF and OUT_VALID clear to 0 immediately, without waiting for a clock edge. In-flight operations are discarded and never produce OUT_VALID.
- After RST_N deasserts, OUT_VALID stays 0 until NSEG enabled edges after the first accepted operation.
- Latency: an operation accepted on edge n appears with OUT_VALID=1 after edge n+NSEG, counting only edges with CE=1.
- Throughput: one operation per CE=1 cycle. Back-to-back inputs give back-to-back OUT_VALID pulses, in order.
- CE=0 on any cycle: all state holds, including OUT_VALID, which stays high if it was high. IN_VALID is ignored on that cycle.
- IN_VALID and CE are independent. IN_VALID=1 with CE=0 is not accepted.
- Subtract-mode inversion and the forced carry-in are applied at acceptance. Each operation keeps its own SUB mode through the pipeline, so mixed add/sub streams are legal.

## Test plan
All scenarios use NBIT=16, NSEG=4.
- Reset: hold RST_N=0 with random inputs. Required: OUT_VALID=0, S=0x0000, COUT=0 and OVF=0 throughout, and immediately on assertion mid-cycle.
- Single add: A=0x00FF, B=0x0001, CIN=0, SUB=0 accepted at edge 0. Required: after edge 4, OUT_VALID=1, S=0x0100, COUT=0, OVF=0; OUT_VALID=0 after edge 5; S then holds 0x0100.
- Stream with bubble: 0xFFFF+0x0001, then 0x7FFF+0x0001, then IN_VALID=0 for one cycle, then 0x1234+0x1111 with CIN=1. Required results in order:
  - S=0x0000, COUT=1, OVF=0;
  - S=0x8000, COUT=0, OVF=1;
  - one cycle with OUT_VALID=0 and S held;
  - S=0x2346, COUT=0, OVF=0.
- Subtract: 0x0003−0x0005 (SUB=1, CIN=1 to check it is ignored), then 0x8000−0x0001. Required: S=0xFFFE, COUT=0, OVF=0; then S=0x7FFF, COUT=1, OVF=1.
- Enable stall: accept 0x0F0F+0x00F1 at edge 0, then CE=0 for edges 2–4. Required: OUT_VALID rises after edge 7 with S=0x1000, and all outputs are frozen during the stall.
- Reset mid-flight: accept two operations, then pulse RST_N low for half a cycle two edges later. Required: OUT_VALID never rises for either operation, S=0x0000, and a fresh operation afterwards completes with latency 4.
